demux4_deser: RTL
=================

Name: demux4_deser

Overview:
- Deserializing 1-to-LANES demultiplexer: the receive-side counterpart of the lane-select multiplexer tree.
- Takes a stream of LANE_W-bit beats over a valid/ready handshake and steers each beat into lane slot cnt.
- Beat 0 goes to lane 0, matching the mux convention that sel=0 selects D[0].
- Emits the assembled LANES*LANE_W-bit word, plus a lane mask, on a registered valid/ready output.

Parameters:
- LANES, 4, number of lanes per word; power of two, >= 2.
- LANE_W, 1, width of one lane/beat in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  LANE_W  incoming beat.
- in_valid  input  1  beat present.
- in_last  input  1  beat closes the current word early; qualified by in_valid.
- in_ready  output  1  block accepts the beat this cycle.
- out_data  output  LANES*LANE_W  assembled word; lane i occupies bits [i*LANE_W +: LANE_W].
- out_mask  output  LANES  bit i set means lane i was filled.
- out_last  output  1  word was terminated by in_last.
- out_valid  output  1  out_* hold a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Internal state:
  - lane counter cnt, width log2(LANES), reset 0.
  - assembly register asm_data / asm_mask, reset 0.
  - output register out_data / out_mask / out_last / out_valid.
- Reset (rst=1 at an edge):
  - cnt=0, asm_data=0, asm_mask=0.
  - out_valid=0, out_data=0, out_mask=0, out_last=0.
  - Any partial word or pending output is discarded. rst overrides all other inputs.
- in_ready = !out_valid || out_ready (combinational). A beat is accepted when in_valid && in_ready.
- Accepted beat, non-completing (cnt != LANES-1 and in_last=0):
  - lane cnt of asm_data <= in_data.
  - asm_mask[cnt] <= 1.
  - cnt <= cnt+1.
- Accepted beat, completing (cnt == LANES-1, or in_last=1):
  - out_data <= asm_data with lane cnt replaced by in_data; lanes above cnt forced to 0.
  - out_mask <= asm_mask | (1<<cnt).
  - out_last <= in_last.
  - out_valid <= 1.
  - asm_data, asm_mask, cnt all <= 0.
- Latency: out_valid rises on the edge that accepts the completing beat. The word is visible the cycle after that beat.
- Output hold:
  - While out_valid && !out_ready, out_* are stable and in_ready=0.
  - cnt and asm_* do not change.
- Drain:
  - out_valid && out_ready with no completing beat accepted: out_valid <= 0. out_data, out_mask and out_last keep their values (don't-care).
  - Simultaneous drain and completing beat (out_valid=1, out_ready=1, completing beat accepted): the output register is overwritten with the new word and out_valid stays 1. This gives full throughput with no bubble.
- in_last on lane 0: word with only lane 0 filled, out_mask = 0...01.
- in_last on lane LANES-1: a full word, with out_last=1.
- Wrap-around: cnt wraps LANES-1 -> 0 only via the completion path; it never increments past LANES-1.
- in_valid=0: no state change except drain. in_data and in_last are ignored when in_valid=0.
- No overflow condition is possible; back-pressure is purely through in_ready.

Test Plan:
- Reset, then stream beats 1,0,1,1 (LANE_W=1) with out_ready=1:
  - out_valid=1 one cycle after the 4th beat.
  - out_data=4'b1101, out_mask=4'b1111, out_last=0.
- Beats 1,1 with in_last on the 2nd beat:
  - out_data=4'b0011, out_mask=4'b0011, out_last=1.
  - cnt restarts, so the next beat lands in lane 0.
- Complete a word with out_ready=0 for 5 cycles:
  - out_* held stable, in_ready=0, offered beats are not consumed.
  - out_ready=1: word drains and in_ready=1 the same cycle.
- Continuous in_valid=1, out_ready=1 for 3 words of 4 beats each:
  - one word every 4 cycles, no lost beats.
  - Back-to-back overwrite on the simultaneous drain/complete cycle keeps out_valid=1.
- Assert rst after 2 beats of a word, and again with out_valid=1 pending:
  - all outputs 0 next cycle.
  - The next 4 beats form a clean word with out_mask=4'b1111.
- LANES=8, LANE_W=4: stream 0x1..0x8 -> out_data=0x87654321, out_mask=8'hFF.

Source files
------------

// File: rtl/demux4_deser.sv
// demux4_deser: steers LANE_W-bit beats into lane slots and emits the assembled word plus a fill mask.
// Latency: the word appears on out_* the cycle after its completing beat is accepted.
// Backpressure: in_ready drops while a held word waits on out_ready; drain and refill may share a cycle.
module demux4_deser #(
    parameter int LANES  = 4,
    parameter int LANE_W = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANE_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic [LANES-1:0]        out_mask,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int               CNT_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LANES - 1);

    // Lane pointer and the partially assembled word.
    logic [CNT_W-1:0]        cnt;
    logic [LANES*LANE_W-1:0] asm_data;
    logic [LANES-1:0]        asm_mask;

    // Word that would be emitted if the current beat completes it.
    logic [LANES*LANE_W-1:0] word_data;
    logic [LANES-1:0]        word_mask;

    logic accept;
    logic complete;

    // A held word blocks new beats unless it is leaving this same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt == LAST_IDX));

    // Merge the incoming beat into lane cnt; lanes above cnt are forced to zero.
    always_comb begin
        word_data = '0;
        word_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) < cnt) begin
                word_data[i*LANE_W +: LANE_W] = asm_data[i*LANE_W +: LANE_W];
                word_mask[i]                  = asm_mask[i];
            end else if (CNT_W'(i) == cnt) begin
                word_data[i*LANE_W +: LANE_W] = in_data;
                word_mask[i]                  = 1'b1;
            end
        end
    end

    // Assembly, completion and output register; a completing beat during a drain overwrites in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            asm_data  <= '0;
            asm_mask  <= '0;
            out_data  <= '0;
            out_mask  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (complete) begin
                    out_data  <= word_data;
                    out_mask  <= word_mask;
                    out_last  <= in_last;
                    out_valid <= 1'b1;
                    asm_data  <= '0;
                    asm_mask  <= '0;
                    cnt       <= '0;
                end else begin
                    asm_data[int'(cnt)*LANE_W +: LANE_W] <= in_data;
                    asm_mask[cnt]                        <= 1'b1;
                    cnt                                  <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
